// File: rtl/mips_bus_pkg.sv
// Shared types and encodings for the multicycle MIPS memory bus controller.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

  localparam logic SW_READ  = 1'b1;
  localparam logic SW_WRITE = 1'b0;

  // Bus direction a requester needs: only an LS store drives the bus.
  function automatic logic req_dir(input req_id_t id, input logic we);
    return (id == REQ_LS && we) ? SW_WRITE : SW_READ;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2
  import mips_bus_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_if,
  input  logic    req_ls,
  input  logic    update,
  input  req_id_t upd_id,
  output logic    grant_valid,
  output req_id_t grant_id
);

  req_id_t last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= REQ_IF;
    end else if (update) begin
      last_q <= upd_id;
    end
  end

  always_comb begin
    grant_valid = req_if | req_ls;
    grant_id    = REQ_IF;
    if (req_if && req_ls) begin
      grant_id = (last_q == REQ_IF) ? REQ_LS : REQ_IF;
    end else if (req_ls) begin
      grant_id = REQ_LS;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory port sequencer: arbitrates IF/LS, drives strobes and bus-switch
// direction, inserts turnaround idles on direction changes.
module mem_bus_ctrl
  import mips_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned TURNAROUND  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_ack,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_cs,
  output logic        mem_we,
  output logic        sw_ctrl,
  output logic [31:0] sw_wdata,
  input  logic [31:0] sw_rdata
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND - 1);

  state_t     state;
  logic [3:0] cnt;
  req_id_t    owner;
  logic       we_q;

  logic       grant_valid;
  req_id_t    grant_id;
  logic       grant_we;
  logic       grant_dir;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_if      (if_req),
    .req_ls      (ls_req),
    .update      (state == DONE),
    .upd_id      (owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    grant_we  = (grant_id == REQ_LS) && ls_we;
    grant_dir = req_dir(grant_id, ls_we);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= REQ_IF;
      we_q     <= 1'b0;
      sw_ctrl  <= SW_READ;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      if_ack   <= 1'b0;
      ls_ack   <= 1'b0;
      rdata    <= '0;
      mem_addr <= '0;
      sw_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner    <= grant_id;
            we_q     <= grant_we;
            mem_addr <= (grant_id == REQ_LS) ? ls_addr : if_addr;
            if (grant_id == REQ_LS) begin
              sw_wdata <= ls_wdata;
            end
            // Direction flips only here, while mem_cs is low, so the switch
            // never turns around under an active access.
            if (grant_dir == sw_ctrl) begin
              state  <= ACCESS;
              mem_cs <= 1'b1;
              mem_we <= grant_we;
              cnt    <= WAIT_LOAD;
            end else begin
              state   <= TURN;
              sw_ctrl <= grant_dir;
              cnt     <= TURN_LOAD;
            end
          end
        end
        TURN: begin
          if (cnt == '0) begin
            state  <= ACCESS;
            mem_cs <= 1'b1;
            mem_we <= we_q;
            cnt    <= WAIT_LOAD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state  <= DONE;
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
            if (!we_q) begin
              rdata <= sw_rdata;
            end
            if (owner == REQ_LS) begin
              ls_ack <= 1'b1;
            end else begin
              if_ack <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: two instances (W=1/T=2 and W=0/T=3) share stimulus.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [31:0] sw_rdata = '0;

  logic        if_ack_a, ls_ack_a, mem_cs_a, mem_we_a, sw_ctrl_a;
  logic [31:0] rdata_a, mem_addr_a, sw_wdata_a;
  logic        if_ack_b, ls_ack_b, mem_cs_b, mem_we_b, sw_ctrl_b;
  logic [31:0] rdata_b, mem_addr_b, sw_wdata_b;

  int checks = 0;
  int errors = 0;
  int viol = 0;
  bit sel = 1'b0;

  logic        o_cs, o_we, o_sw, o_ifa, o_lsa;
  logic [31:0] o_rd, o_addr, o_wd;

  int          r_ackc, r_cs, r_turn, r_ackn;
  logic        r_we;
  logic [31:0] r_addr, r_wd;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.WAIT_CYCLES(1), .TURNAROUND(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_a),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack_a),
    .rdata(rdata_a), .mem_addr(mem_addr_a), .mem_cs(mem_cs_a), .mem_we(mem_we_a),
    .sw_ctrl(sw_ctrl_a), .sw_wdata(sw_wdata_a), .sw_rdata(sw_rdata)
  );

  mem_bus_ctrl #(.WAIT_CYCLES(0), .TURNAROUND(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_b),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack_b),
    .rdata(rdata_b), .mem_addr(mem_addr_b), .mem_cs(mem_cs_b), .mem_we(mem_we_b),
    .sw_ctrl(sw_ctrl_b), .sw_wdata(sw_wdata_b), .sw_rdata(sw_rdata)
  );

  always_comb begin
    if (sel) begin
      o_cs = mem_cs_b; o_we = mem_we_b; o_sw = sw_ctrl_b; o_ifa = if_ack_b; o_lsa = ls_ack_b;
      o_rd = rdata_b; o_addr = mem_addr_b; o_wd = sw_wdata_b;
    end else begin
      o_cs = mem_cs_a; o_we = mem_we_a; o_sw = sw_ctrl_a; o_ifa = if_ack_a; o_lsa = ls_ack_a;
      o_rd = rdata_a; o_addr = mem_addr_a; o_wd = sw_wdata_a;
    end
  end

  // Contention watch: chip select must never be high in a cycle where sw_ctrl just changed.
  logic prev_sw_a = 1'b1;
  logic prev_sw_b = 1'b1;
  always @(negedge clk) begin
    if (sw_ctrl_a !== prev_sw_a && mem_cs_a === 1'b1) viol++;
    if (sw_ctrl_b !== prev_sw_b && mem_cs_b === 1'b1) viol++;
    prev_sw_a = sw_ctrl_a;
    prev_sw_b = sw_ctrl_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issues one request and measures it; ack cycle is counted with the grant edge as N.
  task automatic xact(input bit ls, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rd);
    logic sc0;
    logic own;
    r_ackc = -1; r_cs = 0; r_turn = 0; r_ackn = 0;
    r_we = 1'b0; r_addr = '0; r_wd = '0;
    sw_rdata = rd;
    if (ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    sc0 = o_sw;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 1) begin
        if_addr = '1; ls_addr = '1; ls_wdata = '0;
      end
      own = ls ? o_lsa : o_ifa;
      if (o_cs) begin
        if (r_cs == 0) begin
          r_we = o_we; r_addr = o_addr; r_wd = o_wd;
        end
        r_cs++;
      end else if (r_cs == 0 && o_sw !== sc0) begin
        r_turn++;
      end
      if (own) begin
        r_ackn++;
        if (r_ackc < 0) r_ackc = t;
        if_req = 1'b0;
        ls_req = 1'b0;
      end
      if (r_ackc >= 0 && t >= r_ackc + 2) break;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_sw, o_cs, o_we, o_ifa, o_lsa} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 10000", {o_sw, o_cs, o_we, o_ifa, o_lsa});
    end
    checks++;
    if ({o_rd, o_addr, o_wd} !== 96'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h want zeros", o_rd, o_addr, o_wd);
    end
  endtask

  task automatic test_if_read();
    xact(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h2402_0005);
    checks++;
    if (r_ackc !== 3) begin errors++; $display("FAIL if_read_ack: got %0d want 3", r_ackc); end
    checks++;
    if (r_cs !== 2 || r_turn !== 0 || r_ackn !== 1) begin
      errors++; $display("FAIL if_read_shape: cs %0d turn %0d acks %0d want 2 0 1", r_cs, r_turn, r_ackn);
    end
    checks++;
    if (r_addr !== 32'h0000_0040 || r_we !== 1'b0) begin
      errors++; $display("FAIL if_read_addr: got %h we %b want 00000040 we 0", r_addr, r_we);
    end
    checks++;
    if (o_rd !== 32'h2402_0005) begin errors++; $display("FAIL if_read_data: got %h want 24020005", o_rd); end
    checks++;
    if (o_sw !== 1'b1) begin errors++; $display("FAIL if_read_sw: got %b want 1", o_sw); end
  endtask

  task automatic test_store_after_read();
    xact(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h1111_1111);
    checks++;
    if (r_ackc !== 5) begin errors++; $display("FAIL store_ack: got %0d want 5", r_ackc); end
    checks++;
    if (r_turn !== 2 || r_cs !== 2 || r_ackn !== 1) begin
      errors++; $display("FAIL store_shape: turn %0d cs %0d acks %0d want 2 2 1", r_turn, r_cs, r_ackn);
    end
    checks++;
    if (r_we !== 1'b1 || r_wd !== 32'hDEAD_BEEF || r_addr !== 32'h0000_1000) begin
      errors++; $display("FAIL store_bus: we %b wd %h addr %h want 1 deadbeef 00001000", r_we, r_wd, r_addr);
    end
    checks++;
    if (o_rd !== 32'h2402_0005) begin errors++; $display("FAIL store_rdata: got %h want 24020005", o_rd); end
    checks++;
    if (o_sw !== 1'b0) begin errors++; $display("FAIL store_sw: got %b want 0", o_sw); end
  endtask

  task automatic test_back_to_back();
    int a1, a2, turn, cs_tot;
    logic sc0;
    a1 = -1; a2 = -1; turn = 0; cs_tot = 0;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_1004; ls_wdata = 32'h1234_5678;
    sc0 = o_sw;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (o_cs) cs_tot++;
      if (o_sw !== sc0) turn++;
      if (o_lsa) begin
        if (a1 < 0) a1 = t;
        else begin
          a2 = t;
          ls_req = 1'b0;
          break;
        end
      end
    end
    checks++;
    if (a1 < 0 || a2 < 0 || a2 - a1 !== 4) begin
      errors++; $display("FAIL b2b_spacing: acks at %0d %0d want spacing 4", a1, a2);
    end
    checks++;
    if (turn !== 0 || cs_tot !== 4) begin
      errors++; $display("FAIL b2b_shape: sw changes %0d cs %0d want 0 4", turn, cs_tot);
    end
    checks++;
    if (o_wd !== 32'h1234_5678) begin errors++; $display("FAIL b2b_wdata: got %h want 12345678", o_wd); end
  endtask

  task automatic test_round_robin();
    logic [3:0] order;
    int n;
    order = '0; n = 0;
    do_reset();
    ls_we = 1'b0; ls_addr = 32'h0000_0100; if_addr = 32'h0000_0200;
    if_req = 1'b1; ls_req = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      if (o_lsa) begin order[3 - n] = 1'b1; n++; end
      if (o_ifa) begin order[3 - n] = 1'b0; n++; end
      if (n >= 4) break;
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick(); tick();
    checks++;
    if (n !== 4) begin errors++; $display("FAIL rr_count: got %0d want 4", n); end
    checks++;
    if (order !== 4'b1010) begin errors++; $display("FAIL rr_order: got %b want 1010 (LS IF LS IF)", order); end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    do_reset();
    sw_rdata = 32'hCAFE_F00D;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_2000;
    tick();
    checks++;
    if (o_cs !== 1'b1) begin errors++; $display("FAIL mid_pre_cs: got %b want 1", o_cs); end
    rst_n = 1'b0; ls_req = 1'b0;
    if (o_lsa) acks++;
    tick();
    checks++;
    if ({o_sw, o_cs, o_we, o_ifa, o_lsa} !== 5'b10000 || o_rd !== 32'd0 || o_addr !== 32'd0) begin
      errors++; $display("FAIL mid_reset: ctrl %b rd %h addr %h want 10000 0 0",
                         {o_sw, o_cs, o_we, o_ifa, o_lsa}, o_rd, o_addr);
    end
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (o_lsa || o_ifa) acks++;
    end
    checks++;
    if (acks !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d want 0", acks); end
    xact(1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h0C00_0010);
    checks++;
    if (r_ackc !== 3 || o_rd !== 32'h0C00_0010) begin
      errors++; $display("FAIL mid_after: ack %0d rd %h want 3 0c000010", r_ackc, o_rd);
    end
  endtask

  task automatic test_turnaround3();
    sel = 1'b1;
    do_reset();
    xact(1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'h8C88_0000);
    checks++;
    if (r_ackc !== 2 || r_cs !== 1 || r_turn !== 0) begin
      errors++; $display("FAIL t3_read1: ack %0d cs %0d turn %0d want 2 1 0", r_ackc, r_cs, r_turn);
    end
    xact(1'b1, 1'b1, 32'h0000_0084, 32'hA5A5_A5A5, 32'h0);
    checks++;
    if (r_ackc !== 5 || r_cs !== 1 || r_turn !== 3) begin
      errors++; $display("FAIL t3_write: ack %0d cs %0d turn %0d want 5 1 3", r_ackc, r_cs, r_turn);
    end
    checks++;
    if (r_we !== 1'b1 || r_wd !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL t3_wbus: we %b wd %h want 1 a5a5a5a5", r_we, r_wd);
    end
    xact(1'b0, 1'b0, 32'h0000_0088, 32'h0, 32'h0123_4567);
    checks++;
    if (r_ackc !== 5 || r_turn !== 3 || o_rd !== 32'h0123_4567) begin
      errors++; $display("FAIL t3_read2: ack %0d turn %0d rd %h want 5 3 01234567", r_ackc, r_turn, o_rd);
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL contention: got %0d events want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_store_after_read();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
    test_turnaround3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
